// File: rtl/board_store.sv
// ---------------------------------------------------------------------------
// board_store
//
// Holds one player's playfield (COLS x ROWS cells, 3-bit colour code each)
// and serves the pixel renderer with zero-latency reads. Locking a piece
// writes its four cells, then a scan walks the rows from the bottom (row
// ROWS-1) to the top (row 0), collapsing every full row it finds. The
// opponent's attacks push a garbage row in from the bottom.
//
// Ports
//   pclk, rstn        clock, asynchronous active-low reset
//   clr               synchronous board clear, aborts any sequence
//   raddr / rdata     render read port, address = y*COLS + x, 0 = empty
//   lock_req          level request to lock the piece on lx*/ly*/ltype
//   lock_ack          one-cycle pulse when a lock is accepted
//   garb_req          level request to insert one garbage row
//   garb_hole         empty column of the garbage row (>= COLS means 0)
//   garb_ack          one-cycle pulse when a garbage row is inserted
//   busy              high while a lock sequence is running
//   done              one-cycle pulse at the end of a lock sequence
//   lines             rows cleared by the last lock, valid from done
//   overflow          one-cycle pulse: garbage pushed a used row 0 out
// ---------------------------------------------------------------------------
module board_store #(
    parameter int         COLS         = 10,
    parameter int         ROWS         = 20,
    parameter logic [2:0] GARBAGE_TYPE = 3'd7
) (
    input  logic       pclk,
    input  logic       rstn,
    input  logic       clr,
    input  logic [7:0] raddr,
    output logic [2:0] rdata,
    input  logic       lock_req,
    input  logic [4:0] lx1,
    input  logic [4:0] ly1,
    input  logic [4:0] lx2,
    input  logic [4:0] ly2,
    input  logic [4:0] lx3,
    input  logic [4:0] ly3,
    input  logic [4:0] lx4,
    input  logic [4:0] ly4,
    input  logic [2:0] ltype,
    output logic       lock_ack,
    input  logic       garb_req,
    input  logic [3:0] garb_hole,
    output logic       garb_ack,
    output logic       busy,
    output logic       done,
    output logic [2:0] lines,
    output logic       overflow
);

    localparam int CELLS = COLS * ROWS;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SHIFT,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Row 0 (top) sits in the least significant slice, so a garbage insert
    // is a single concatenation that drops the old top row.
    logic [ROWS-1:0][COLS-1:0][2:0] board;

    logic [4:0] scan_row;
    logic [4:0] shift_row;
    logic [2:0] clear_cnt;

    logic do_lock;
    logic do_garb;
    logic scan_hit;
    logic scan_step;
    logic shift_step;
    logic shift_top;
    logic finish;

    logic                  row_full;
    logic                  top_used;
    logic [3:0]            hole;
    logic [COLS-1:0][2:0]  garb_row;
    logic [4:0]            px [4];
    logic [4:0]            py [4];
    logic [4:0]            rd_row;
    logic [3:0]            rd_col;

    // The renderer reads straight out of the register array, so the value
    // it sees mid-shift is simply the board as it stands that cycle.
    assign rd_row = 5'(raddr / 8'(COLS));
    assign rd_col = 4'(raddr % 8'(COLS));
    assign rdata  = (raddr < 8'(CELLS)) ? board[rd_row][rd_col] : 3'd0;

    assign busy = (state != IDLE);

    // Gather the four piece coordinates so the lock write can loop over them.
    always_comb begin
        px[0] = lx1;
        py[0] = ly1;
        px[1] = lx2;
        py[1] = ly2;
        px[2] = lx3;
        py[2] = ly3;
        px[3] = lx4;
        py[3] = ly4;
    end

    // Row-status helpers: is the row under the scan pointer completely
    // filled, and does the top row hold anything that garbage would push out.
    always_comb begin
        row_full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (board[scan_row][c] == 3'd0) begin
                row_full = 1'b0;
            end
        end
        top_used = |board[0];
    end

    // Build the incoming garbage row; an out-of-range hole falls back to
    // column 0 so the row can never arrive full.
    always_comb begin
        hole = (garb_hole >= 4'(COLS)) ? 4'd0 : garb_hole;
        for (int c = 0; c < COLS; c++) begin
            garb_row[c] = (4'(c) == hole) ? 3'd0 : GARBAGE_TYPE;
        end
    end

    // State register.
    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the one-hot action strobes that steer the
    // datapath. clr overrides everything; lock beats garbage in IDLE.
    always_comb begin
        state_next = state;
        do_lock    = 1'b0;
        do_garb    = 1'b0;
        scan_hit   = 1'b0;
        scan_step  = 1'b0;
        shift_step = 1'b0;
        shift_top  = 1'b0;
        finish     = 1'b0;
        if (clr) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (lock_req) begin
                        do_lock    = 1'b1;
                        state_next = SCAN;
                    end else if (garb_req) begin
                        do_garb = 1'b1;
                    end
                end
                SCAN: begin
                    if (row_full) begin
                        scan_hit   = 1'b1;
                        state_next = SHIFT;
                    end else if (scan_row == 5'd0) begin
                        finish     = 1'b1;
                        state_next = DONE;
                    end else begin
                        scan_step = 1'b1;
                    end
                end
                SHIFT: begin
                    if (shift_row != 5'd0) begin
                        shift_step = 1'b1;
                    end else begin
                        shift_top  = 1'b1;
                        state_next = SCAN;
                    end
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Scan and shift pointers plus the saturating clear counter. After a
    // collapse the scan pointer is left alone so the row that dropped into
    // its place gets checked too.
    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            scan_row  <= 5'd0;
            shift_row <= 5'd0;
            clear_cnt <= 3'd0;
        end else if (clr) begin
            clear_cnt <= 3'd0;
        end else begin
            if (do_lock) begin
                scan_row  <= 5'(ROWS - 1);
                clear_cnt <= 3'd0;
            end
            if (scan_step) begin
                scan_row <= scan_row - 5'd1;
            end
            if (scan_hit) begin
                shift_row <= scan_row;
                if (clear_cnt != 3'd7) begin
                    clear_cnt <= clear_cnt + 3'd1;
                end
            end
            if (shift_step) begin
                shift_row <= shift_row - 5'd1;
            end
        end
    end

    // Playfield storage. Lock cells outside the board are dropped; a shift
    // step moves one row down per cycle and the last step empties row 0.
    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            board <= '0;
        end else if (clr) begin
            board <= '0;
        end else if (do_lock) begin
            for (int i = 0; i < 4; i++) begin
                if ((px[i] < 5'(COLS)) && (py[i] < 5'(ROWS))) begin
                    board[py[i]][px[i][3:0]] <= ltype;
                end
            end
        end else if (do_garb) begin
            board <= {garb_row, board[ROWS-1:1]};
        end else if (shift_step) begin
            board[shift_row] <= board[shift_row - 5'd1];
        end else if (shift_top) begin
            board[0] <= '0;
        end
    end

    // Handshake pulses and the cleared-rows result. lines is loaded as the
    // FSM enters DONE so it is already valid while done is high.
    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            lock_ack <= 1'b0;
            garb_ack <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            lines    <= 3'd0;
        end else begin
            lock_ack <= do_lock;
            garb_ack <= do_garb;
            done     <= finish;
            overflow <= do_garb & top_used;
            if (clr) begin
                lines <= 3'd0;
            end else if (finish) begin
                lines <= clear_cnt;
            end
        end
    end

endmodule

// File: tb/tb_board_store.sv
// ---------------------------------------------------------------------------
// tb_board_store
//
// Directed and randomized checks of board_store against a row-list model of
// the playfield: a lock writes cells, then full rows are removed and empty
// rows prepended; done latency is derived from where each full row sits.
// ---------------------------------------------------------------------------
module tb_board_store;

    localparam int COLS = 10;
    localparam int ROWS = 20;
    localparam int CELLS = COLS * ROWS;
    localparam int GARB = 7;

    logic       pclk;
    logic       rstn;
    logic       clr;
    logic [7:0] raddr;
    logic [2:0] rdata;
    logic       lock_req;
    logic [4:0] lx1, ly1, lx2, ly2, lx3, ly3, lx4, ly4;
    logic [2:0] ltype;
    logic       lock_ack;
    logic       garb_req;
    logic [3:0] garb_hole;
    logic       garb_ack;
    logic       busy;
    logic       done;
    logic [2:0] lines;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int model [ROWS][COLS];

    board_store dut (
        .pclk      (pclk),
        .rstn      (rstn),
        .clr       (clr),
        .raddr     (raddr),
        .rdata     (rdata),
        .lock_req  (lock_req),
        .lx1       (lx1),
        .ly1       (ly1),
        .lx2       (lx2),
        .ly2       (ly2),
        .lx3       (lx3),
        .ly3       (ly3),
        .lx4       (lx4),
        .ly4       (ly4),
        .ltype     (ltype),
        .lock_ack  (lock_ack),
        .garb_req  (garb_req),
        .garb_hole (garb_hole),
        .garb_ack  (garb_ack),
        .busy      (busy),
        .done      (done),
        .lines     (lines),
        .overflow  (overflow)
    );

    // Free-running clock.
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Hard stop in case something in the bench itself stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Put a piece on the lock inputs.
    task automatic applyStimulus(input int x1, input int y1, input int x2, input int y2,
                                 input int x3, input int y3, input int x4, input int y4,
                                 input int typ);
        lx1   = 5'(x1);
        ly1   = 5'(y1);
        lx2   = 5'(x2);
        ly2   = 5'(y2);
        lx3   = 5'(x3);
        ly3   = 5'(y3);
        lx4   = 5'(x4);
        ly4   = 5'(y4);
        ltype = 3'(typ);
    endtask

    function automatic void model_clear();
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                model[y][x] = 0;
    endfunction

    // Apply the piece on the lock inputs, remove full rows, and work out the
    // expected done latency: 20 non-full scans plus, for each cleared row,
    // one scan and one shift per row from its current position up to row 0.
    function automatic void model_lock(output int lat, output int cleared);
        int xs [4];
        int ys [4];
        bit full [ROWS];
        int tmp [ROWS][COLS];
        int dst;
        xs = '{int'(lx1), int'(lx2), int'(lx3), int'(lx4)};
        ys = '{int'(ly1), int'(ly2), int'(ly3), int'(ly4)};
        for (int i = 0; i < 4; i++)
            if (xs[i] < COLS && ys[i] < ROWS)
                model[ys[i]][xs[i]] = int'(ltype);
        lat = ROWS;
        cleared = 0;
        for (int y = ROWS - 1; y >= 0; y--) begin
            full[y] = 1'b1;
            for (int x = 0; x < COLS; x++)
                if (model[y][x] == 0) full[y] = 1'b0;
            if (full[y]) begin
                lat += y + cleared + 2;
                cleared++;
            end
        end
        dst = ROWS - 1;
        for (int y = ROWS - 1; y >= 0; y--) begin
            if (!full[y]) begin
                for (int x = 0; x < COLS; x++) tmp[dst][x] = model[y][x];
                dst--;
            end
        end
        for (int y = dst; y >= 0; y--)
            for (int x = 0; x < COLS; x++) tmp[y][x] = 0;
        model = tmp;
    endfunction

    function automatic int model_top_used();
        int used = 0;
        for (int x = 0; x < COLS; x++)
            if (model[0][x] != 0) used = 1;
        return used;
    endfunction

    function automatic void model_garbage(input int hole);
        int h = (hole >= COLS) ? 0 : hole;
        for (int y = 0; y < ROWS - 1; y++)
            for (int x = 0; x < COLS; x++)
                model[y][x] = model[y + 1][x];
        for (int x = 0; x < COLS; x++)
            model[ROWS - 1][x] = (x == h) ? 0 : GARB;
    endfunction

    // Random cell: occasionally off the board, otherwise preferably an empty
    // cell near the bottom so that rows actually complete.
    function automatic void pick_cell(output int x, output int y);
        int cand [$];
        int r;
        int k;
        r = int'($urandom_range(7));
        if (r == 0) begin
            x = int'($urandom_range(31, 10));
            y = int'($urandom_range(19));
        end else if (r == 1) begin
            x = int'($urandom_range(9));
            y = int'($urandom_range(31, 20));
        end else begin
            for (int yy = 15; yy < ROWS; yy++)
                for (int xx = 0; xx < COLS; xx++)
                    if (model[yy][xx] == 0) cand.push_back(yy * COLS + xx);
            if (cand.size() == 0) begin
                x = int'($urandom_range(9));
                y = int'($urandom_range(19));
            end else begin
                k = cand[$urandom_range(cand.size() - 1)];
                x = k % COLS;
                y = k / COLS;
            end
        end
    endfunction

    task automatic read_check(input string tag, input int addr, input int expected);
        raddr = 8'(addr);
        #1;
        checkOutput(tag, 32'(rdata), 32'(expected));
    endtask

    // Sweep the whole read port against the model; one comparison per sweep.
    task automatic check_board(input string tag);
        int bad = 0;
        int first = -1;
        for (int a = 0; a < CELLS; a++) begin
            raddr = 8'(a);
            #1;
            if (rdata !== 3'(model[a / COLS][a % COLS])) begin
                bad++;
                if (first < 0) first = a;
            end
        end
        checkOutput($sformatf("%s board mismatches (first addr %0d)", tag, first), 32'(bad), 32'd0);
    endtask

    task automatic clear_board();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        model_clear();
        checkOutput("busy after clr", 32'(busy), 32'd0);
        checkOutput("lines after clr", 32'(lines), 32'd0);
    endtask

    // Raise lock_req (optionally with garb_req) and wait for the ack.
    task automatic lock_begin(input bit also_garb, input int hole, output int lat, output int lin);
        int n = 0;
        int got = 0;
        int cleared;
        tick();
        lock_req = 1'b1;
        if (also_garb) begin
            garb_hole = 4'(hole);
            garb_req  = 1'b1;
        end
        while (got == 0 && n < 8) begin
            tick();
            n++;
            if (lock_ack === 1'b1) got = 1;
        end
        lock_req = 1'b0;
        checkOutput("lock_ack cycles", 32'(n), 32'd1);
        model_lock(lat, cleared);
        lin = (cleared > 7) ? 7 : cleared;
    endtask

    task automatic lock_finish(input int lat, input int lin);
        int n;
        int garb_seen = 0;
        tick();
        n = 1;
        checkOutput("lock_ack pulse width", 32'(lock_ack), 32'd0);
        checkOutput("busy during lock", 32'(busy), 32'd1);
        while (done !== 1'b1 && n < 300) begin
            if (garb_ack === 1'b1) garb_seen++;
            tick();
            n++;
        end
        checkOutput("done latency", 32'(n), 32'(lat));
        checkOutput("lines at done", 32'(lines), 32'(lin));
        checkOutput("garb_ack while busy", 32'(garb_seen), 32'd0);
        tick();
        checkOutput("done pulse width", 32'(done), 32'd0);
        checkOutput("busy after done", 32'(busy), 32'd0);
        checkOutput("lines held", 32'(lines), 32'(lin));
    endtask

    task automatic lock_piece(input int x1, input int y1, input int x2, input int y2,
                              input int x3, input int y3, input int x4, input int y4,
                              input int typ);
        int lat;
        int lin;
        applyStimulus(x1, y1, x2, y2, x3, y3, x4, y4, typ);
        lock_begin(1'b0, 0, lat, lin);
        lock_finish(lat, lin);
    endtask

    // Wait for a garbage ack with garb_req already high.
    task automatic garb_finish(input int hole);
        int n = 0;
        int got = 0;
        int exp_ovf;
        while (got == 0 && n < 8) begin
            tick();
            n++;
            if (garb_ack === 1'b1) got = 1;
        end
        garb_req = 1'b0;
        checkOutput("garb_ack cycles", 32'(n), 32'd1);
        exp_ovf = model_top_used();
        checkOutput("overflow", 32'(overflow), 32'(exp_ovf));
        checkOutput("busy after garbage", 32'(busy), 32'd0);
        model_garbage(hole);
        tick();
        checkOutput("garb_ack pulse width", 32'(garb_ack), 32'd0);
        checkOutput("overflow pulse width", 32'(overflow), 32'd0);
    endtask

    task automatic garbage(input int hole);
        tick();
        garb_hole = 4'(hole);
        garb_req  = 1'b1;
        garb_finish(hole);
    endtask

    initial begin
        int lat;
        int lin;
        int done_seen;
        int xs [4];
        int ys [4];

        rstn     = 1'b0;
        clr      = 1'b0;
        raddr    = 8'd0;
        lock_req = 1'b0;
        garb_req = 1'b0;
        garb_hole = 4'd0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_clear();
        #23;
        rstn = 1'b1;
        tick();

        $display("[TB] reset state");
        check_board("reset");
        read_check("rdata addr 200", 200, 0);
        read_check("rdata addr 255", 255, 0);
        checkOutput("busy reset", 32'(busy), 32'd0);
        checkOutput("lines reset", 32'(lines), 32'd0);
        checkOutput("lock_ack reset", 32'(lock_ack), 32'd0);
        checkOutput("garb_ack reset", 32'(garb_ack), 32'd0);
        checkOutput("done reset", 32'(done), 32'd0);
        checkOutput("overflow reset", 32'(overflow), 32'd0);

        $display("[TB] square lock, no clear");
        lock_piece(0, 19, 1, 19, 0, 18, 1, 18, 4);
        read_check("cell 190", 190, 4);
        read_check("cell 181", 181, 4);
        check_board("square");
        clear_board();
        check_board("after clr");

        $display("[TB] single row clear at row 19");
        lock_piece(0, 19, 1, 19, 2, 19, 3, 19, 3);
        lock_piece(4, 19, 5, 19, 12, 19, 3, 25, 3);
        lock_piece(3, 18, 3, 18, 20, 0, 0, 31, 2);
        applyStimulus(6, 19, 7, 19, 8, 19, 9, 19, 1);
        lock_begin(1'b0, 0, lat, lin);
        checkOutput("model latency single clear", 32'(lat), 32'd41);
        lock_finish(lat, lin);
        read_check("cell 193 after collapse", 193, 2);
        check_board("single clear");
        clear_board();

        $display("[TB] four row clear");
        for (int j = 0; j < 9; j++) begin
            for (int i = 0; i < 4; i++) begin
                xs[i] = (4 * j + i) % 9;
                ys[i] = 16 + (4 * j + i) / 9;
            end
            lock_piece(xs[0], ys[0], xs[1], ys[1], xs[2], ys[2], xs[3], ys[3], 1 + (j % 7));
        end
        applyStimulus(9, 16, 9, 17, 9, 18, 9, 19, 1);
        lock_begin(1'b0, 0, lat, lin);
        checkOutput("model lines tetris", 32'(lin), 32'd4);
        lock_finish(lat, lin);
        check_board("tetris");

        $display("[TB] asynchronous reset mid-scan");
        applyStimulus(4, 10, 5, 10, 4, 11, 5, 11, 2);
        lock_begin(1'b0, 0, lat, lin);
        tick();
        tick();
        checkOutput("busy mid-scan", 32'(busy), 32'd1);
        checkOutput("lines held mid-scan", 32'(lines), 32'd4);
        read_check("cell 104 before reset", 104, 2);
        rstn = 1'b0;
        #1;
        model_clear();
        checkOutput("busy in reset", 32'(busy), 32'd0);
        checkOutput("lines in reset", 32'(lines), 32'd0);
        read_check("cell 104 in reset", 104, 0);
        check_board("in reset");
        rstn = 1'b1;

        $display("[TB] lock and garbage together");
        applyStimulus(0, 19, 1, 19, 2, 19, 3, 19, 5);
        lock_begin(1'b1, 4, lat, lin);
        lock_finish(lat, lin);
        garb_finish(4);
        check_board("lock then garbage");

        $display("[TB] garbage overflow");
        lock_piece(5, 0, 14, 0, 15, 0, 16, 0, 6);
        garbage(12);
        check_board("overflow");

        $display("[TB] clr mid-shift");
        clear_board();
        lock_piece(0, 19, 1, 19, 2, 19, 3, 19, 2);
        lock_piece(4, 19, 5, 19, 6, 19, 7, 19, 2);
        applyStimulus(8, 19, 9, 19, 15, 3, 9, 19, 3);
        lock_begin(1'b0, 0, lat, lin);
        for (int i = 0; i < 4; i++) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        model_clear();
        checkOutput("busy after mid-shift clr", 32'(busy), 32'd0);
        checkOutput("lines after mid-shift clr", 32'(lines), 32'd0);
        checkOutput("done after mid-shift clr", 32'(done), 32'd0);
        check_board("mid-shift clr");
        done_seen = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (done === 1'b1) done_seen++;
        end
        checkOutput("no done after abort", 32'(done_seen), 32'd0);

        $display("[TB] randomized locks and garbage");
        for (int op = 0; op < 30; op++) begin
            if ($urandom_range(2) == 0) begin
                garbage(int'($urandom_range(15)));
            end else begin
                for (int i = 0; i < 4; i++) pick_cell(xs[i], ys[i]);
                lock_piece(xs[0], ys[0], xs[1], ys[1], xs[2], ys[2], xs[3], ys[3],
                           int'($urandom_range(7, 1)));
            end
            check_board($sformatf("random op %0d", op));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/board_store.md
Name: board_store

Overview:
- Owns one player's 10x20 playfield and answers the pixel renderer's cell reads (raddr/rdata).
- Writes the cells of a locked piece, then scans for and collapses full rows, and reports the number of rows cleared.
- Inserts garbage rows from the bottom when the opponent attacks.
- Instantiated once per player, between the game-logic FSM and the display.

Parameters:
- COLS, 10, playfield width in cells.
- ROWS, 20, playfield height in cells.
- GARBAGE_TYPE, 3'd7, cell code written into garbage rows.

Ports:
- pclk  in  1  pixel/system clock.
- rstn  in  1  asynchronous active-low reset.
- clr  in  1  synchronous board clear (new game).
- raddr  in  8  render read address = y*10+x.
- rdata  out  3  cell code at raddr; 0 = empty, 1..7 = piece colour.
- lock_req  in  1  level request to lock a piece.
- lx1,ly1,lx2,ly2,lx3,ly3,lx4,ly4  in  5 each  cell coordinates of the piece (x 0..9, y 0..19).
- ltype  in  3  colour code of the piece.
- lock_ack  out  1  one-cycle pulse: lock accepted.
- garb_req  in  1  level request to insert one garbage row.
- garb_hole  in  4  empty column of the garbage row.
- garb_ack  out  1  one-cycle pulse: garbage inserted.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse: lock sequence finished.
- lines  out  3  rows cleared by the last lock; valid from done onward, held until the next lock.
- overflow  out  1  one-cycle pulse: garbage pushed a non-empty row 0 off the top.

Behaviour:
- Reset: rstn is asynchronous, active-low; the clock is pclk.
  - On reset all 200 cells = 0 and the FSM goes to IDLE.
  - lock_ack, garb_ack, done, overflow and lines all reset to 0.
- Storage: a 200x3 register array; cell index = y*10+x.
- rdata is combinational from raddr, with zero latency, and is valid in every state including mid-shift.
  - raddr >= 200 returns 0.
- clr: in any state, at the next edge all cells = 0 and the FSM goes to IDLE.
  - Any sequence in progress is aborted with no done pulse.
  - lines is cleared to 0.
- FSM states: IDLE, SCAN, SHIFT, DONE.
- IDLE arbitration at each edge, in priority order: clr, then lock_req, then garb_req.
  - Requests are sampled only in IDLE; requests arriving in other states wait and are not acked.
  - The requester must hold req until it sees ack and drop it in the cycle after ack.
- Lock (IDLE with lock_req high):
  - The same edge writes ltype into all 4 cells.
  - A cell with x >= 10 or y >= 20 is skipped; occupied cells are overwritten.
  - That edge also sets lock_ack for one cycle, sets r = 19, zeroes the clear counter, and moves to SCAN.
- SCAN, one row per cycle:
  - If row r has all 10 cells non-zero: counter += 1 (saturates at 7), k = r, go to SHIFT.
  - Else if r == 0: go to DONE.
  - Else: r -= 1.
- SHIFT, one row per cycle:
  - If k > 0: row k <= row k-1 and k -= 1.
  - If k == 0: row 0 <= all empty and return to SCAN with r unchanged (the same row is rescanned).
  - A clear at row r therefore costs 1 scan cycle plus r+1 shift cycles.
- DONE: done pulses for one cycle, lines <= counter, then IDLE.
  - With no clears, done rises 20 cycles after lock_ack rises.
- Garbage (IDLE with garb_req high and lock_req low), all at one edge:
  - Rows shift up: row k <= row k+1 for k = 0..18.
  - Row 19 <= GARBAGE_TYPE in every column except garb_hole, which is set to 0.
  - garb_hole >= 10 is treated as column 0.
  - garb_ack pulses; overflow pulses if the old row 0 had any non-zero cell.
  - The FSM stays in IDLE; there is no scan, because the garbage row always has a hole.
- busy is high in SCAN, SHIFT and DONE.

Test Plan:
- Reset then read all 200 addresses, plus raddr = 200 and 255 -> rdata = 0 everywhere; busy, lines and all pulses = 0.
- Lock type 4 at (0,19),(1,19),(0,18),(1,18) -> lock_ack one cycle; cells 190,191,180,181 read 4; done rises exactly 20 cycles after lock_ack; lines = 0.
- Preload row 19 columns 0..5 and row 18 cell (3,18) = 2; lock type 1 at (6..9,19) -> done 41 cycles after ack; lines = 1; cell 193 = 2; row 19 otherwise empty; row 0 empty.
- Fill rows 16..19 except column 9, then lock an I piece type 1 at (9,16..19) -> lines = 4; rows 16..19 empty.
- Assert lock_req and garb_req together in IDLE -> lock wins; garb_ack comes only after done; then row 19 = 7 except the hole column; overflow pulses only if row 0 was occupied.
- Pulse clr mid-SHIFT -> the next cycle has all cells 0 and the FSM in IDLE, with no done pulse; pull rstn low mid-SCAN -> immediate clear with no clock edge.
